// File: rtl/mips_pkg.sv
// Shared types for the MIPS multiply/divide unit.
//   mdu_op_t    : operation codes carried on req_op
//   mdu_state_t : iteration FSM states
package mips_pkg;

    localparam int unsigned MDU_XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One combinational radix-2 step shared by multiply and divide.
//   is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc     : partial product high half (mult) / partial remainder (div)
//   opa     : multiplier shifting out LSB-first with product low bits
//             entering at the top (mult), or dividend shifting out
//             MSB-first with quotient bits entering at the bottom (div)
//   opb     : multiplicand / divisor magnitude
//   acc_nxt, opa_nxt : values after this step
module mdu_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] opa_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    always_comb begin
        acc_nxt = acc;
        opa_nxt = opa;
        sum     = '0;
        trial   = '0;
        diff    = '0;
        if (is_div) begin
            trial = {acc, opa[XLEN-1]};
            diff  = trial - {1'b0, opb};
            // Remainder is always below the divisor, so bit XLEN of diff is a clean borrow flag.
            if (!diff[XLEN]) begin
                acc_nxt = diff[XLEN-1:0];
                opa_nxt = {opa[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = trial[XLEN-1:0];
                opa_nxt = {opa[XLEN-2:0], 1'b0};
            end
        end else begin
            sum     = {1'b0, acc} + (opa[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
            acc_nxt = sum[XLEN:1];
            opa_nxt = {sum[0], opa[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_op    : operation request (mdu_op_t), opnd_a = rs, opnd_b = rt
//   req_ready           : high in IDLE; request accepted on valid & ready & !flush
//   flush               : abandon any in-flight operation, HI/LO untouched
//   mf_req / mf_stall   : MFHI/MFLO in EX, stall while busy
//   busy, done          : iteration in progress / one-cycle HI/LO write pulse
//   hi, lo              : architectural HI/LO
module mips_muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned XLEN   = MDU_XLEN_DEFAULT,
    parameter int unsigned UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] opnd_a,
    input  logic [XLEN-1:0] opnd_b,
    output logic            req_ready,
    input  logic            flush,
    input  logic            mf_req,
    output logic            mf_stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned Steps = XLEN / UNROLL;
    localparam int unsigned CntW  = $clog2(Steps + 1);
    localparam logic [CntW-1:0] StepsInit = CntW'(Steps);

    mdu_state_t      state, state_nxt;
    logic [CntW-1:0] cnt, cnt_nxt;
    logic [XLEN-1:0] acc, acc_nxt;
    logic [XLEN-1:0] opa, opa_nxt;
    logic [XLEN-1:0] opb, opb_nxt;
    logic            op_div, op_div_nxt;
    logic            neg_q, neg_q_nxt;     // negate product or quotient
    logic            neg_r, neg_r_nxt;     // negate remainder
    logic [XLEN-1:0] hi_nxt, lo_nxt;

    // UNROLL chained steps per cycle
    logic [XLEN-1:0] chain_acc [UNROLL+1];
    logic [XLEN-1:0] chain_opa [UNROLL+1];

    assign chain_acc[0] = acc;
    assign chain_opa[0] = opa;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        mdu_step #(.XLEN(XLEN)) u_step (
            .is_div  (op_div),
            .acc     (chain_acc[i]),
            .opa     (chain_opa[i]),
            .opb     (opb),
            .acc_nxt (chain_acc[i+1]),
            .opa_nxt (chain_opa[i+1])
        );
    end

    mdu_op_t         op;
    logic            accept;
    logic            is_signed;
    logic            sa, sb;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        op        = mdu_op_t'(req_op);
        accept    = req_valid && (state == IDLE) && !flush;
        is_signed = (op == MDU_MULT) || (op == MDU_DIV);
        sa        = is_signed && opnd_a[XLEN-1];
        sb        = is_signed && opnd_b[XLEN-1];
        abs_a     = sa ? -opnd_a : opnd_a;
        abs_b     = sb ? -opnd_b : opnd_b;
        prod      = {acc, opa};

        state_nxt  = state;
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        opa_nxt    = opa;
        opb_nxt    = opb;
        op_div_nxt = op_div;
        neg_q_nxt  = neg_q;
        neg_r_nxt  = neg_r;
        hi_nxt     = hi;
        lo_nxt     = lo;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            op_div_nxt = (op == MDU_DIV) || (op == MDU_DIVU);
                            acc_nxt    = '0;
                            opa_nxt    = abs_a;
                            opb_nxt    = abs_b;
                            neg_q_nxt  = sa ^ sb;
                            neg_r_nxt  = sa;
                            cnt_nxt    = StepsInit;
                            state_nxt  = RUN;
                            // Divide by zero: preload the fixed result and let FIX write it.
                            if (op_div_nxt && (opnd_b == '0)) begin
                                acc_nxt   = opnd_a;
                                opa_nxt   = '1;
                                neg_q_nxt = 1'b0;
                                neg_r_nxt = 1'b0;
                                state_nxt = FIX;
                            end
                        end
                        MDU_MTHI: hi_nxt = opnd_a;
                        MDU_MTLO: lo_nxt = opnd_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    acc_nxt = chain_acc[UNROLL];
                    opa_nxt = chain_opa[UNROLL];
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CntW'(1)) begin
                        state_nxt = FIX;
                    end
                end
            end
            FIX: begin
                state_nxt = IDLE;
                if (!flush) begin
                    if (op_div) begin
                        lo_nxt = neg_q ? -opa : opa;
                        hi_nxt = neg_r ? -acc : acc;
                    end else begin
                        {hi_nxt, lo_nxt} = neg_q ? -prod : prod;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            acc    <= acc_nxt;
            opa    <= opa_nxt;
            opb    <= opb_nxt;
            op_div <= op_div_nxt;
            neg_q  <= neg_q_nxt;
            neg_r  <= neg_r_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FIX) && !flush;
    assign mf_stall  = mf_req && busy;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: default instance (32-bit, UNROLL=1)
// plus a 16-bit UNROLL=4 instance. Expected HI/LO pairs are queued at issue
// and popped by per-instance monitors on the cycle after done.
module tb_mips_muldiv_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst, req_valid, flush, mf_req;
    logic [2:0]  req_op;
    logic [31:0] opnd_a, opnd_b;
    logic        req_ready, mf_stall, busy, done;
    logic [31:0] hi, lo;

    // 16-bit UNROLL=4 instance
    logic        b_rst, b_req_valid, b_flush, b_mf_req;
    logic [2:0]  b_req_op;
    logic [15:0] b_opnd_a, b_opnd_b;
    logic        b_req_ready, b_mf_stall, b_busy, b_done;
    logic [15:0] b_hi, b_lo;

    mips_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .req_ready(req_ready), .flush(flush),
        .mf_req(mf_req), .mf_stall(mf_stall), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    mips_muldiv_unit #(.XLEN(16), .UNROLL(4)) dut_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_op(b_req_op),
        .opnd_a(b_opnd_a), .opnd_b(b_opnd_b), .req_ready(b_req_ready), .flush(b_flush),
        .mf_req(b_mf_req), .mf_stall(b_mf_stall), .busy(b_busy), .done(b_done),
        .hi(b_hi), .lo(b_lo)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_a [$];
    logic [63:0] exp_b [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: compare HI/LO the cycle after done
    logic a_seen_done = 1'b0;
    logic b_seen_done = 1'b0;

    initial forever begin
        @(negedge clk);
        if (a_seen_done) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL A unexpected done: got hi=%0h lo=%0h expected no result", hi, lo);
            end else begin
                chk("A hi/lo", {hi, lo}, exp_a.pop_front());
            end
        end
        a_seen_done = done;
    end

    initial forever begin
        @(negedge clk);
        if (b_seen_done) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL B unexpected done: got hi=%0h lo=%0h expected no result", b_hi, b_lo);
            end else begin
                chk("B hi/lo", {32'h0, 16'h0, b_hi, 16'h0, b_lo}, exp_b.pop_front());
            end
        end
        b_seen_done = b_done;
    end

    // Issue one MULT/DIV on instance A and measure busy length, done position, stall cycles.
    task automatic run_a(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int exp_busy,
                         input string name, output int stall_cnt);
        int n;
        int done_at;
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        chk({name, " ready"}, 64'(req_ready), 64'(1));
        exp_a.push_back({eh, el});
        req_valid = 1'b1;
        req_op    = op;
        opnd_a    = a;
        opnd_b    = b;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        done_at = 0;
        stall_cnt = 0;
        while (busy && n < 200) begin
            n++;
            if (done) done_at = n;
            if (mf_stall) stall_cnt++;
            @(negedge clk);
        end
        chk({name, " busy cycles"}, 64'(n), 64'(exp_busy));
        chk({name, " done cycle"}, 64'(done_at), 64'(exp_busy));
    endtask

    task automatic mt_a(input mdu_op_t op, input logic [31:0] a);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        opnd_a    = a;
        opnd_b    = '0;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sc;
        int n;
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; mf_req = 1'b0;
        req_op = 3'd0; opnd_a = '0; opnd_b = '0;
        b_rst = 1'b1; b_req_valid = 1'b0; b_flush = 1'b0; b_mf_req = 1'b0;
        b_req_op = 3'd0; b_opnd_a = '0; b_opnd_b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        b_rst = 1'b0;

        // Reset state
        chk("reset hi", 64'(hi), 64'(0));
        chk("reset lo", 64'(lo), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset ready", 64'(req_ready), 64'(1));

        // Arithmetic vectors
        run_a(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, "multu max", sc);
        run_a(MDU_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, "mult -7*3", sc);
        run_a(MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div -7/2", sc);
        run_a(MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, "div 7/-2", sc);
        run_a(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, "div ovf", sc);
        run_a(MDU_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1,  "divu by 0", sc);
        run_a(MDU_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 33, "divu 100/7", sc);
        run_a(MDU_MULTU, 32'h1234_5678, 32'h100,       32'h0000_0012, 32'h3456_7800, 33, "multu shift", sc);

        // MTHI then MFHI
        mt_a(MDU_MTHI, 32'h1234);
        mf_req = 1'b1;
        chk("mthi hi", 64'(hi), 64'h1234);
        chk("mthi busy", 64'(busy), 64'(0));
        chk("mthi stall", 64'(mf_stall), 64'(0));
        chk("mthi done", 64'(done), 64'(0));

        // MFHI held through a MULT stalls for every busy cycle
        run_a(MDU_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 33, "mult mf", sc);
        chk("mf stall cycles", 64'(sc), 64'(33));
        chk("mf stall released", 64'(mf_stall), 64'(0));
        mf_req = 1'b0;

        // Flush at RUN cycle 10
        mt_a(MDU_MTHI, 32'hA);
        mt_a(MDU_MTLO, 32'hB);
        @(negedge clk);
        req_valid = 1'b1; req_op = MDU_DIVU; opnd_a = 32'd100; opnd_b = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-flush busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'(0));
        chk("flush ready", 64'(req_ready), 64'(1));
        repeat (40) @(negedge clk);
        chk("flush hi", 64'(hi), 64'hA);
        chk("flush lo", 64'(lo), 64'hB);

        // Flush with request in IDLE: not accepted
        flush = 1'b1; req_valid = 1'b1; req_op = MDU_MULT; opnd_a = 32'd3; opnd_b = 32'd3;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        chk("flush+req busy", 64'(busy), 64'(0));
        repeat (40) @(negedge clk);
        chk("flush+req lo", 64'(lo), 64'hB);

        // Reset mid-MULT
        req_valid = 1'b1; req_op = MDU_MULT; opnd_a = 32'd5; opnd_b = 32'd5;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst mid hi", 64'(hi), 64'(0));
        chk("rst mid lo", 64'(lo), 64'(0));
        chk("rst mid ready", 64'(req_ready), 64'(1));
        chk("rst mid busy", 64'(busy), 64'(0));

        // 16-bit UNROLL=4: back-to-back with req_valid held
        @(negedge clk);
        exp_b.push_back({32'h0, 32'h0000_EA60});
        b_req_valid = 1'b1; b_req_op = MDU_MULTU; b_opnd_a = 16'd300; b_opnd_b = 16'd200;
        @(negedge clk);
        exp_b.push_back({32'h0000_0006, 32'h0000_008E});
        b_req_op = MDU_DIVU; b_opnd_a = 16'd1000; b_opnd_b = 16'd7;
        n = 0;
        while (b_busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("B multu busy cycles", 64'(n), 64'(5));
        chk("B ready after done", 64'(b_req_ready), 64'(1));
        @(negedge clk);
        chk("B held req accepted", 64'(b_busy), 64'(1));
        b_req_valid = 1'b0;
        n = 0;
        while (b_busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("B divu busy cycles", 64'(n), 64'(5));

        repeat (3) @(negedge clk);
        chk("A results drained", 64'(exp_a.size()), 64'(0));
        chk("B results drained", 64'(exp_b.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, sitting beside the EX stage of the 5-stage pipeline.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO; serves MFHI/MFLO reads.
- Parametrised in data width and bits retired per cycle.
- Provides a ready/stall handshake so the pipeline holds IF/ID/EX while a result is pending.

Parameters:
- XLEN, 32, operand and HI/LO width.
- UNROLL, 1, bits retired per iteration cycle. Legal values: 1, 2, 4. XLEN must be a multiple of UNROLL.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  operation request from EX.
- req_op  in  3  operation code (mdu_op_t).
- opnd_a  in  XLEN  rs value (dividend/multiplicand/MT source).
- opnd_b  in  XLEN  rt value (divisor/multiplier).
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- flush  in  1  kill any in-flight operation (exception/over flush).
- mf_req  in  1  EX holds an MFHI/MFLO.
- mf_stall  out  1  mf_req & busy; pipeline must hold.
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse when HI/LO are written by MULT/DIV.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

Behaviour:
- Reset (rst=1 at edge): state IDLE; hi=0, lo=0, busy=0, done=0, req_ready=1. Applies mid-operation: the operation is discarded.
- req_ready = (state==IDLE). Requests while not ready are ignored; the requester holds req_valid.
- States: IDLE -> RUN -> FIX -> IDLE.
  - IDLE: on MULT/MULTU/DIV/DIVU accept, latch |a|, |b| (signed ops) or raw (unsigned ops), plus sign flags. Clear accumulator, load counter = XLEN/UNROLL, go to RUN.
  - RUN: each cycle applies UNROLL shift-add (mult) or restoring-subtract (div) steps, then decrements the counter. When the counter reaches 1, go to FIX on the next edge.
  - FIX: apply sign correction, write hi/lo, pulse done, go to IDLE.
- Sign correction:
  - Product negated if the operand signs differ (signed op).
  - Quotient negated if the signs differ.
  - Remainder takes the sign of the dividend.
- MULT result: hi = product[2*XLEN-1:XLEN], lo = product[XLEN-1:0].
- DIV result: lo = quotient, hi = remainder.
- Latency: busy=1 for XLEN/UNROLL+1 cycles after the accept edge. hi/lo carry the new value on the cycle after done. Defaults give 33 cycles.
- MTHI/MTLO: accepted only in IDLE; write hi or lo at that edge; busy stays 0; no done pulse.
- Divide by zero: detected at accept; skips RUN and goes straight to FIX. Result lo = all ones, hi = opnd_a. busy lasts 1 cycle.
- Signed overflow (most-negative / -1): lo = 0x80000000 (XLEN-scaled), hi = 0; this falls out naturally, no special case.
- flush: in RUN or FIX, return to IDLE at the next edge with hi/lo unchanged and done=0. Flush in IDLE is a no-op. Flush and req_valid in the same IDLE cycle: the request is not accepted.
- rst and flush together: rst wins.
- mf_stall is combinational; hi/lo reads are valid whenever mf_stall=0.

Decomposition:
- mips_pkg holds:
  - typedef enum mdu_op_t: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - typedef mdu_state_t: IDLE, RUN, FIX.
  - localparam MDU_XLEN_DEFAULT.
- One sub-module, mdu_step: combinational single-bit mult/div step on (acc, opA, opB, is_div). It is instantiated UNROLL times in a chain inside generate.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 33 after accept; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=-7 (0xFFFFFFF9), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> busy 1 cycle; lo=0xFFFFFFFF, hi=5.
- MTHI 0x1234 then MFHI same cycle+1 -> hi=0x1234, no busy, mf_stall=0. MFHI during MULT -> mf_stall=1 until the cycle after done.
- flush at RUN cycle 10 of DIVU 100/7 with prior hi=0xA, lo=0xB -> IDLE next cycle, hi/lo unchanged, no done. rst mid-MULT -> hi=lo=0, req_ready=1.
- UNROLL=4, XLEN=16: MULTU 300*200 -> busy 5 cycles; hi=0x0000, lo=0xEA60. Back-to-back request held high is accepted the cycle after done.
